// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch PC sequencer with a single IF/ID slot.
// Issues word-address fetches from cur_pc, loads the IF/ID slot on each fetch, applies
// redirects (branches/jumps), and supports halting/resuming. Keeps fetch and redirect counts.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hazard unit holds the IF/ID slot
//   redirect_valid/_pc         taken control-flow change and its word-address target
//   halt_req, resume           stop fetching / leave the halted state
//   imem_req/_addr/_ack/_rdata instruction memory handshake (rdata valid with ack)
//   cur_pc                     current PC register
//   if_valid/_pc/_instr        IF/ID slot contents
//   flush                      one-cycle pulse after each accepted redirect
//   fetch_cnt, redirect_cnt    completed fetches (wraps), accepted redirects (saturates)
module pc_sequencer #(
  parameter logic [29:0] RESET_PC = 30'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [29:0] cur_pc,
  output logic        if_valid,
  output logic [29:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush,
  output logic [31:0] fetch_cnt,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StRedir, StHalted} state_e;

  state_e      state_q, state_d;
  logic [29:0] cur_pc_q, cur_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [29:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        flush_q, flush_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic        fetch;

  always_comb begin
    // No request while the slot is occupied and held, or while a redirect/halt is pending.
    imem_req = (state_q == StRun) & ~redirect_valid & ~halt_req & ~(if_valid_q & stall);
    fetch    = imem_req & imem_ack;

    state_d        = state_q;
    cur_pc_d       = cur_pc_q;
    if_valid_d     = if_valid_q;
    if_pc_d        = if_pc_q;
    if_instr_d     = if_instr_q;
    flush_d        = 1'b0;
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    if (redirect_valid) begin
      // Redirect wins over stall, halt and ack.
      cur_pc_d   = redirect_pc;
      if_valid_d = 1'b0;
      flush_d    = 1'b1;
      if (redirect_cnt_q != 16'hFFFF) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
      state_d = (state_q == StHalted) ? StHalted : StRedir;
    end else begin
      if (fetch) begin
        if_valid_d  = 1'b1;
        if_pc_d     = cur_pc_q;
        if_instr_d  = imem_rdata;
        cur_pc_d    = cur_pc_q + 30'd1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else if (!stall) begin
        if_valid_d = 1'b0;
      end

      case (state_q)
        StBoot:   state_d = StRun;
        StRun:    if (halt_req) state_d = StHalted;
        StRedir:  state_d = StRun;
        StHalted: if (resume && !halt_req) state_d = StRun;
        default:  state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StBoot;
      cur_pc_q       <= RESET_PC;
      if_valid_q     <= 1'b0;
      if_pc_q        <= 30'd0;
      if_instr_q     <= 32'd0;
      flush_q        <= 1'b0;
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cur_pc_q       <= cur_pc_d;
      if_valid_q     <= if_valid_d;
      if_pc_q        <= if_pc_d;
      if_instr_q     <= if_instr_d;
      flush_q        <= flush_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign imem_addr    = cur_pc_q;
  assign cur_pc       = cur_pc_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign flush        = flush_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
